// File: rtl/aes_block_sequencer_if.sv
// Register bus between the block sequencer and the aes core.
interface aes_block_sequencer_if;
  localparam int unsigned ADDR_W = 8;
  localparam int unsigned DATA_W = 32;

  logic              aes_cs;
  logic              aes_we;
  logic [ADDR_W-1:0] aes_addr;
  logic [DATA_W-1:0] aes_wdata;
  logic [DATA_W-1:0] aes_rdata;

  // Sequencer side drives the transaction, core returns read data combinationally.
  modport master (
    output aes_cs,
    output aes_we,
    output aes_addr,
    output aes_wdata,
    input  aes_rdata
  );

  modport slave (
    input  aes_cs,
    input  aes_we,
    input  aes_addr,
    input  aes_wdata,
    output aes_rdata
  );
endinterface

// File: rtl/aes_block_sequencer.sv
// Runs one complete aes block operation over the core register bus:
// key, config, key expansion, block, next, result readback.
module aes_block_sequencer #(
  parameter int unsigned SETTLE  = 2,
  parameter int unsigned TIMEOUT = 5000,
  parameter int unsigned TO_W    = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         encdec,
  input  logic         keylen,
  input  logic         key_reuse,
  input  logic [255:0] key,
  input  logic [127:0] block_in,
  output logic [127:0] block_out,
  output logic         busy,
  output logic         done,
  output logic         err,
  aes_block_sequencer_if.master core_bus
);

  localparam int unsigned KEY_W  = 256;
  localparam int unsigned BLK_W  = 128;
  localparam int unsigned WORD_W = 32;
  localparam int unsigned ADDR_W = 8;
  localparam int unsigned IDX_W  = 3;

  localparam logic [ADDR_W-1:0] ADDR_CTRL   = 8'h08;
  localparam logic [ADDR_W-1:0] ADDR_STATUS = 8'h09;
  localparam logic [ADDR_W-1:0] ADDR_CONFIG = 8'h0a;
  localparam logic [ADDR_W-1:0] ADDR_KEY    = 8'h10;
  localparam logic [ADDR_W-1:0] ADDR_BLOCK  = 8'h20;
  localparam logic [ADDR_W-1:0] ADDR_RESULT = 8'h30;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_WR_KEY,
    ST_WR_CFG,
    ST_INIT,
    ST_SETTLE_I,
    ST_WAIT_RDY,
    ST_WR_BLK,
    ST_NEXT,
    ST_SETTLE_N,
    ST_WAIT_VAL,
    ST_RD_RES,
    ST_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [TO_W-1:0]     tcnt_q, tcnt_d;

  logic                encdec_q, encdec_d;
  logic                keylen_q, keylen_d;
  logic                reuse_q, reuse_d;
  logic [KEY_W-1:0]    key_q, key_d;
  logic [BLK_W-1:0]    block_q, block_d;

  logic                key_loaded_q, key_loaded_d;
  logic [KEY_W-1:0]    exp_key_q, exp_key_d;
  logic                exp_keylen_q, exp_keylen_d;

  logic [BLK_W-1:0]    block_out_q, block_out_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                err_q, err_d;

  logic                cs_q, cs_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [WORD_W-1:0]   wdata_q, wdata_d;

  logic                key_match;
  logic                poll_expired;
  logic                settle_last;

  // State and output registers; bus outputs hold the transaction of the current cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      idx_q        <= '0;
      tcnt_q       <= '0;
      encdec_q     <= 1'b0;
      keylen_q     <= 1'b0;
      reuse_q      <= 1'b0;
      key_q        <= '0;
      block_q      <= '0;
      key_loaded_q <= 1'b0;
      exp_key_q    <= '0;
      exp_keylen_q <= 1'b0;
      block_out_q  <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      cs_q         <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      tcnt_q       <= tcnt_d;
      encdec_q     <= encdec_d;
      keylen_q     <= keylen_d;
      reuse_q      <= reuse_d;
      key_q        <= key_d;
      block_q      <= block_d;
      key_loaded_q <= key_loaded_d;
      exp_key_q    <= exp_key_d;
      exp_keylen_q <= exp_keylen_d;
      block_out_q  <= block_out_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      err_q        <= err_d;
      cs_q         <= cs_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
    end
  end

  // Next-state sequencing, then decode of the bus transaction for the next cycle.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    tcnt_d       = tcnt_q;
    encdec_d     = encdec_q;
    keylen_d     = keylen_q;
    reuse_d      = reuse_q;
    key_d        = key_q;
    block_d      = block_q;
    key_loaded_d = key_loaded_q;
    exp_key_d    = exp_key_q;
    exp_keylen_d = exp_keylen_q;
    block_out_d  = block_out_q;
    err_d        = err_q;
    cs_d         = 1'b0;
    we_d         = 1'b0;
    addr_d       = addr_q;
    wdata_d      = wdata_q;

    key_match    = (key == exp_key_q) && (keylen == exp_keylen_q);
    poll_expired = (tcnt_q == TO_W'(TIMEOUT - 1));
    settle_last  = (tcnt_q == TO_W'(SETTLE - 1));

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          encdec_d = encdec;
          keylen_d = keylen;
          key_d    = key;
          block_d  = block_in;
          err_d    = 1'b0;
          idx_d    = '0;
          reuse_d  = key_reuse && key_loaded_q && key_match;
          // A different key invalidates whatever the core has expanded.
          if (!key_match) key_loaded_d = 1'b0;
          state_d  = reuse_d ? ST_WR_CFG : ST_WR_KEY;
        end
      end
      ST_WR_KEY: begin
        idx_d = idx_q + IDX_W'(1);
        if (idx_q == IDX_W'(7)) begin
          idx_d   = '0;
          state_d = ST_WR_CFG;
        end
      end
      ST_WR_CFG: begin
        idx_d   = '0;
        state_d = reuse_q ? ST_WR_BLK : ST_INIT;
      end
      ST_INIT: begin
        tcnt_d  = '0;
        state_d = ST_SETTLE_I;
      end
      ST_SETTLE_I: begin
        tcnt_d = tcnt_q + TO_W'(1);
        if (settle_last) begin
          tcnt_d  = '0;
          state_d = ST_WAIT_RDY;
        end
      end
      ST_WAIT_RDY: begin
        if (core_bus.aes_rdata[0]) begin
          key_loaded_d = 1'b1;
          exp_key_d    = key_q;
          exp_keylen_d = keylen_q;
          idx_d        = '0;
          state_d      = ST_WR_BLK;
        end else if (poll_expired) begin
          err_d        = 1'b1;
          key_loaded_d = 1'b0;
          state_d      = ST_DONE;
        end else begin
          tcnt_d = tcnt_q + TO_W'(1);
        end
      end
      ST_WR_BLK: begin
        idx_d = idx_q + IDX_W'(1);
        if (idx_q == IDX_W'(3)) begin
          idx_d   = '0;
          state_d = ST_NEXT;
        end
      end
      ST_NEXT: begin
        tcnt_d  = '0;
        state_d = ST_SETTLE_N;
      end
      ST_SETTLE_N: begin
        tcnt_d = tcnt_q + TO_W'(1);
        if (settle_last) begin
          tcnt_d  = '0;
          state_d = ST_WAIT_VAL;
        end
      end
      ST_WAIT_VAL: begin
        if (core_bus.aes_rdata[1]) begin
          idx_d   = '0;
          state_d = ST_RD_RES;
        end else if (poll_expired) begin
          err_d        = 1'b1;
          key_loaded_d = 1'b0;
          state_d      = ST_DONE;
        end else begin
          tcnt_d = tcnt_q + TO_W'(1);
        end
      end
      ST_RD_RES: begin
        // RESULT0 is read first and ends up in the top word.
        block_out_d = {block_out_q[BLK_W-WORD_W-1:0], core_bus.aes_rdata};
        idx_d       = idx_q + IDX_W'(1);
        if (idx_q == IDX_W'(3)) begin
          idx_d   = '0;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_DONE);

    case (state_d)
      ST_WR_KEY: begin
        cs_d    = 1'b1;
        we_d    = 1'b1;
        addr_d  = ADDR_KEY | ADDR_W'(idx_d);
        wdata_d = key_d[{~idx_d, 5'b0} +: WORD_W];
      end
      ST_WR_CFG: begin
        cs_d    = 1'b1;
        we_d    = 1'b1;
        addr_d  = ADDR_CONFIG;
        wdata_d = {30'b0, keylen_d, encdec_d};
      end
      ST_INIT: begin
        cs_d    = 1'b1;
        we_d    = 1'b1;
        addr_d  = ADDR_CTRL;
        wdata_d = 32'h1;
      end
      ST_WR_BLK: begin
        cs_d    = 1'b1;
        we_d    = 1'b1;
        addr_d  = ADDR_BLOCK | ADDR_W'(idx_d[1:0]);
        wdata_d = block_d[{~idx_d[1:0], 5'b0} +: WORD_W];
      end
      ST_NEXT: begin
        cs_d    = 1'b1;
        we_d    = 1'b1;
        addr_d  = ADDR_CTRL;
        wdata_d = 32'h2;
      end
      ST_WAIT_RDY, ST_WAIT_VAL: begin
        cs_d   = 1'b1;
        addr_d = ADDR_STATUS;
      end
      ST_RD_RES: begin
        cs_d   = 1'b1;
        addr_d = ADDR_RESULT | ADDR_W'(idx_d[1:0]);
      end
      default: begin
        cs_d = 1'b0;
      end
    endcase
  end

  assign block_out          = block_out_q;
  assign busy               = busy_q;
  assign done               = done_q;
  assign err                = err_q;
  assign core_bus.aes_cs    = cs_q;
  assign core_bus.aes_we    = we_q;
  assign core_bus.aes_addr  = addr_q;
  assign core_bus.aes_wdata = wdata_q;

endmodule
